// File: rtl/data_memory_stage.sv
// rtl/data_memory_stage.sv - MEM-stage data memory with byte/half/word access and post-reset zero-fill
module data_memory_stage #(
   parameter int ADDR_BITS = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [1:0]  MemSizeM,
   input  logic        MemSignedM,
   input  logic [31:0] AddressM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] MemReadDataM,
   output logic        MisalignM,
   output logic        BusyM
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] cnt_q, cnt_d;
   logic [31:0]          mem_q [DEPTH];

   logic [ADDR_BITS-1:0] word_idx;
   logic [1:0]           lane;
   logic                 size_byte;
   logic                 size_half;
   logic                 size_word;
   logic                 store_en;
   logic [3:0]           byte_en;
   logic [31:0]          wr_word;
   logic [31:0]          rd_word;
   logic [7:0]           rd_byte;
   logic [15:0]          rd_half;
   logic                 unused_addr_hi;

   assign word_idx       = AddressM[ADDR_BITS+1:2];
   assign lane           = AddressM[1:0];
   assign unused_addr_hi = ^AddressM[31:ADDR_BITS+2];

   // MemSizeM = 11 behaves as a word access.
   assign size_byte = (MemSizeM == 2'b00);
   assign size_half = (MemSizeM == 2'b01);
   assign size_word = MemSizeM[1];

   assign BusyM = (state_q == ST_INIT);

   // Fill sequencer next state: walk every word once, then park in READY until the next reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (Reset) begin
         state_d = ST_INIT;
         cnt_d   = '0;
      end else if (state_q == ST_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == {ADDR_BITS{1'b1}}) begin
            state_d = ST_READY;
         end
      end
   end

   // Fill sequencer state register.
   always_ff @(posedge Clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   // Misalignment is decoded even while busy so hazard logic sees it immediately.
   always_comb begin
      MisalignM = 1'b0;
      if (MemReadM || MemWriteM) begin
         MisalignM = (size_half && AddressM[0]) || (size_word && (lane != 2'b00));
      end
   end

   assign store_en = MemWriteM && !BusyM && !MisalignM;

   // Byte-lane enables and lane-replicated store data for sub-word stores.
   always_comb begin
      byte_en = 4'b0000;
      wr_word = WriteDataM;
      if (size_byte) begin
         byte_en = 4'b0001 << lane;
         wr_word = {4{WriteDataM[7:0]}};
      end else if (size_half) begin
         byte_en = lane[1] ? 4'b1100 : 4'b0011;
         wr_word = {2{WriteDataM[15:0]}};
      end else begin
         byte_en = 4'b1111;
      end
   end

   // Array write port: zero-fill while busy, otherwise byte-enabled stores; nothing on the reset cycle.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (BusyM) begin
            mem_q[cnt_q] <= 32'h0;
         end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
               if (byte_en[b]) begin
                  mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
               end
            end
         end
      end
   end

   assign rd_word = mem_q[word_idx];
   assign rd_byte = rd_word[8*lane +: 8];
   assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

   // Load path: pre-write contents, gated to zero when idle, busy or misaligned.
   always_comb begin
      MemReadDataM = 32'h0;
      if (MemReadM && !BusyM && !MisalignM) begin
         if (size_byte) begin
            MemReadDataM = {{24{MemSignedM & rd_byte[7]}}, rd_byte};
         end else if (size_half) begin
            MemReadDataM = {{16{MemSignedM & rd_half[15]}}, rd_half};
         end else begin
            MemReadDataM = rd_word;
         end
      end
   end

endmodule
